sync_fifo_param: RTL

Parametrised successor to the team's fixed 48-bit synchronous FIFO, for single-clock buffering between datapath stages.
- Adds configurable width and depth, runtime almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags.
- Optional first-word-fall-through read mode.
- Drop-in for the old block when DATA_W=48 and thresholds are tied off.

---
 rtl/sync_fifo_param_pkg.sv | 25 ++
 rtl/sync_fifo_param_if.sv | 42 ++++
 rtl/sync_fifo_param_fifo_mem_dp.sv | 37 +++
 rtl/sync_fifo_param.sv | 110 +++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Latency: n/a (types, defaults and a constant helper only).
// Backpressure: n/a.
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int DEPTH_DEF  = 16;

  // Registered status flags, all derived from the next-state occupancy.
  typedef struct packed {
    logic empty;
    logic full;
    logic almst_full;
    logic almst_empty;
  } fifo_flags_t;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Request/status bundle between a producer/consumer pair and the FIFO.
// Latency: n/a (wiring only).
// Backpressure: the consumer of the bundle watches full/empty; the FIFO rejects anything it cannot accept.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
);

  logic              i_wr_en;
  logic              i_rd_en;
  logic [DATA_W-1:0] i_data;
  logic [ADDR_W:0]   i_afull_thresh;
  logic [ADDR_W:0]   i_aempty_thresh;
  logic              i_clr_err;

  logic [DATA_W-1:0] o_fifo_data;
  logic              o_fifo_empty;
  logic              o_fifo_full;
  logic              o_fifo_almst_full;
  logic              o_fifo_almst_empty;
  logic [ADDR_W:0]   o_fifo_count;
  logic              o_overflow;
  logic              o_underflow;

  // Side that issues writes/reads and observes status.
  modport master (
    output i_wr_en, i_rd_en, i_data, i_afull_thresh, i_aempty_thresh, i_clr_err,
    input  o_fifo_data, o_fifo_empty, o_fifo_full, o_fifo_almst_full,
           o_fifo_almst_empty, o_fifo_count, o_overflow, o_underflow
  );

  // The FIFO itself.
  modport slave (
    input  i_wr_en, i_rd_en, i_data, i_afull_thresh, i_aempty_thresh, i_clr_err,
    output o_fifo_data, o_fifo_empty, o_fifo_full, o_fifo_almst_full,
           o_fifo_almst_empty, o_fifo_count, o_overflow, o_underflow
  );

endinterface

// File: rtl/sync_fifo_param_fifo_mem_dp.sv
// Simple dual-port register array: synchronous write, registered read with optional write-through bypass.
// Latency: read data appears one cycle after rd_en (or byp_en).
// Backpressure: none; the caller guarantees address validity.
module fifo_mem_dp
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              byp_en,
  input  logic [DATA_W-1:0] byp_dat,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: no reset, contents are only meaningful once written.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Output register: a read takes the old word even if the same slot is written this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rd_dat <= '0;
    else if (rd_en)  rd_dat <= mem[rd_addr];
    else if (byp_en) rd_dat <= byp_dat;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy and sticky errors; FIFO_FWFT_EN selects first-word-fall-through.
// Latency: standard mode data 1 cycle after accepted read; FWFT head visible 1 cycle after write into empty.
// Backpressure: writes rejected when full (unless a read frees a slot), reads rejected when empty; both flagged sticky.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input logic i_clk,
  input logic i_rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int CW = ADDR_W + 1;

  logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_nxt;
  fifo_flags_t       flags_q, flags_nxt;
  logic              ovf_q, unf_q;
  logic              rd_acc, wr_acc;
  logic              mem_we, mem_rd, byp_en;
  logic [DATA_W-1:0] mem_rdat;
`ifdef FIFO_FWFT_EN
  logic              mem_nempty, load;
`endif

  // Accept decisions from registered flags, and how they map onto the array.
  always_comb begin
    rd_acc = bus.i_rd_en & ~flags_q.empty;
    wr_acc = bus.i_wr_en & (~flags_q.full | rd_acc);
`ifdef FIFO_FWFT_EN
    // The output register is the head slot: refill it whenever it is free or being popped.
    mem_nempty = (wr_ptr_q != rd_ptr_q);
    load       = (flags_q.empty | rd_acc) & (mem_nempty | wr_acc);
    mem_rd     = load & mem_nempty;
    byp_en     = load & ~mem_nempty;
    mem_we     = wr_acc & ~byp_en;
`else
    mem_rd     = rd_acc;
    byp_en     = 1'b0;
    mem_we     = wr_acc;
`endif
  end

  // Next occupancy and the flags it implies against the live thresholds.
  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CW'(1);
    flags_nxt.empty       = (count_nxt == '0);
    flags_nxt.full        = (count_nxt == CW'(DEPTH));
    flags_nxt.almst_full  = (count_nxt >= bus.i_afull_thresh);
    flags_nxt.almst_empty = (count_nxt <= bus.i_aempty_thresh);
  end

  // Pointer, count and flag state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{empty: 1'b1, full: 1'b0, almst_full: 1'b0, almst_empty: 1'b1};
    end else begin
      if (mem_we) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + CW'(1);
      count_q <= count_nxt;
      flags_q <= flags_nxt;
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.i_wr_en & flags_q.full & ~rd_acc) | (ovf_q & ~bus.i_clr_err);
      unf_q <= (bus.i_rd_en & flags_q.empty) | (unf_q & ~bus.i_clr_err);
    end
  end

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_dat  (bus.i_data),
    .rd_en   (mem_rd),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .byp_en  (byp_en),
    .byp_dat (bus.i_data),
    .rd_dat  (mem_rdat)
  );

  assign bus.o_fifo_data        = mem_rdat;
  assign bus.o_fifo_empty       = flags_q.empty;
  assign bus.o_fifo_full        = flags_q.full;
  assign bus.o_fifo_almst_full  = flags_q.almst_full;
  assign bus.o_fifo_almst_empty = flags_q.almst_empty;
  assign bus.o_fifo_count       = count_q;
  assign bus.o_overflow         = ovf_q;
  assign bus.o_underflow        = unf_q;

endmodule
